// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_lsu
//  Brief    : Data-memory load/store responder. Word-wide RAM with byte-lane
//             stores, sign/zero-extended loads, misalignment/illegal-request
//             detection and a valid/ready handshake that stalls the core.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  dm_type,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        stall
);

  localparam logic [2:0] DM_W  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_HU = 3'b010;
  localparam logic [2:0] DM_B  = 3'b011;
  localparam logic [2:0] DM_BU = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_RESP  = 3'd1,
    S_RD_WAIT  = 3'd2,
    S_RD_RESP  = 3'd3,
    S_ERR_RESP = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          lane_q, lane_d;
  logic [2:0]          type_q, type_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [31:0]         ram_q [2**ADDR_W];

  logic                req_any;
  logic                accept;
  logic                req_err;
  logic                store_ok;
  logic                load_ok;
  logic [ADDR_W-1:0]   req_idx;
  logic [3:0]          wr_be;
  logic [31:0]         wr_data;
  logic [31:0]         ld_word;
  logic [15:0]         ld_half;
  logic [7:0]          ld_byte;
  logic [31:0]         ld_ext;
  logic                unused_addr;

  // Address bits above the RAM index are deliberately ignored (wrap-around).
  assign unused_addr = ^addr[31:ADDR_W+2];
  assign req_idx     = addr[ADDR_W+1:2];

  assign req_any   = mem_read | mem_write;
  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_any & req_ready;
  assign rsp_valid = (state_q == S_WR_RESP) | (state_q == S_RD_RESP) |
                     (state_q == S_ERR_RESP);
  assign err       = (state_q == S_ERR_RESP);
  assign stall     = (req_any & ~req_ready) | (state_q != S_IDLE);
  assign rdata     = rdata_q;

  // Classify the incoming request: any illegal combination is an error.
  always_comb begin
    req_err = 1'b0;
    if (mem_read && mem_write)                               req_err = 1'b1;
    if (dm_type > DM_BU)                                     req_err = 1'b1;
    if (mem_write && (dm_type == DM_HU || dm_type == DM_BU)) req_err = 1'b1;
    if (dm_type == DM_W && addr[1:0] != 2'b00)               req_err = 1'b1;
    if ((dm_type == DM_H || dm_type == DM_HU) && addr[0])    req_err = 1'b1;
  end

  assign store_ok = accept & mem_write & ~req_err;
  assign load_ok  = accept & mem_read  & ~req_err;

  // Byte enables and lane-replicated store data from the access size.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = wdata;
    case (dm_type)
      DM_W: begin
        wr_be   = 4'b1111;
        wr_data = wdata;
      end
      DM_H: begin
        wr_be   = addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata[15:0]}};
      end
      DM_B: begin
        wr_be   = 4'b0001 << addr[1:0];
        wr_data = {4{wdata[7:0]}};
      end
      default: begin
        wr_be   = 4'b0000;
        wr_data = wdata;
      end
    endcase
  end

  // RAM write port: stores land on the accept edge; no write while in reset.
  always_ff @(posedge clk) begin
    if (store_ok && rstn) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) ram_q[req_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
      end
    end
  end

  // Lane selection and extension of the addressed RAM word for loads.
  always_comb begin
    ld_word = ram_q[idx_q];
    ld_half = lane_q[1] ? ld_word[31:16] : ld_word[15:0];
    case (lane_q)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    case (type_q)
      DM_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
      DM_HU:   ld_ext = {16'h0000, ld_half};
      DM_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      DM_BU:   ld_ext = {24'h000000, ld_byte};
      default: ld_ext = ld_word;
    endcase
  end

  // Next-state, request capture and response data.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    type_d  = type_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_d = S_ERR_RESP;
            rdata_d = 32'h0000_0000;
          end else if (store_ok) begin
            state_d = S_WR_RESP;
            rdata_d = 32'h0000_0000;
          end else if (load_ok) begin
            state_d = S_RD_WAIT;
            idx_d   = req_idx;
            lane_d  = addr[1:0];
            type_d  = dm_type;
          end
        end
      end
      S_RD_WAIT: begin
        state_d = S_RD_RESP;
        rdata_d = ld_ext;
      end
      S_WR_RESP, S_RD_RESP, S_ERR_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and captured-request registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      type_q  <= 3'b000;
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      type_q  <= type_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_lsu
//  Brief    : Self-checking bench for dmem_lsu: directed scenarios followed by
//             randomized traffic against a byte-addressed reference memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  dm_type = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        err;
  logic        stall;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_rdata = 32'h0;
  logic [7:0]  mb [1024];
  logic [31:0] got;

  dmem_lsu #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .dm_type   (dm_type),
    .addr      (addr),
    .wdata     (wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rdata     (rdata),
    .err       (err),
    .stall     (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Reference: legality rules for a request.
  function automatic bit model_err(bit rd, bit wr, logic [2:0] t, logic [31:0] a);
    if (rd && wr) return 1'b1;
    if (t > 3'd4) return 1'b1;
    if (wr && (t == 3'd2 || t == 3'd4)) return 1'b1;
    if (t == 3'd0 && (a % 4) != 0) return 1'b1;
    if ((t == 3'd1 || t == 3'd2) && (a % 2) != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: little-endian byte memory of 1 KiB, address wraps modulo size.
  task automatic model_store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd);
    int b;
    int n;
    b = int'(a % 1024);
    n = (t == 3'd0) ? 4 : (t == 3'd1) ? 2 : 1;
    for (int k = 0; k < n; k++) mb[b + k] = 8'((wd >> (8 * k)) & 32'hFF);
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a);
    int          b;
    logic [15:0] h;
    logic [7:0]  y;
    b = int'(a % 1024);
    y = mb[b];
    if (t == 3'd0) return {mb[b + 3], mb[b + 2], mb[b + 1], mb[b]};
    h = {mb[(b + 1) % 1024], mb[b]};
    case (t)
      3'd1:    return h[15] ? (32'hFFFF0000 | 32'(h)) : 32'(h);
      3'd2:    return 32'(h);
      3'd3:    return y[7] ? (32'hFFFFFF00 | 32'(y)) : 32'(y);
      default: return 32'(y);
    endcase
  endfunction

  // One request/response exchange, checked against the reference model.
  task automatic txn(input string tag, input bit rd, input bit wr, input logic [2:0] t,
                     input logic [31:0] a, input logic [31:0] wd, output logic [31:0] obs);
    bit          e;
    logic [31:0] exp_d;
    int          lat;
    int          exp_lat;
    e = model_err(rd, wr, t, a);
    @(negedge clk);
    chk({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, " hold"}, rdata, last_rdata);
    mem_read = rd; mem_write = wr; dm_type = t; addr = a; wdata = wd;
    @(posedge clk);
    if (e) begin
      exp_d = 32'h0; exp_lat = 1;
    end else if (wr) begin
      model_store(t, a, wd); exp_d = 32'h0; exp_lat = 1;
    end else begin
      exp_d = model_load(t, a); exp_lat = 2;
    end
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (rsp_valid || lat >= 6) break;
      chk({tag, " wait stall"}, {31'b0, stall}, 32'd1);
      mem_read = 1'b0; mem_write = 1'b0;
      dm_type = 3'($urandom()); addr = $urandom(); wdata = $urandom();
    end
    mem_read = 1'b0; mem_write = 1'b0;
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " err"}, {31'b0, err}, {31'b0, e});
    chk({tag, " rdata"}, rdata, exp_d);
    obs = rdata;
    last_rdata = exp_d;
  endtask

  initial begin
    #2 rstn = 1'b0;
    @(negedge clk);
    chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset err", {31'b0, err}, 32'd0);
    chk("reset req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Fill the words used by the random phase so every load is defined.
    for (int i = 0; i < 16; i++) txn("init sw", 1'b0, 1'b1, 3'd0, 32'(i * 4), $urandom(), got);

    // Word store then load.
    txn("t1 sw", 1'b0, 1'b1, 3'd0, 32'h10, 32'hDEADBEEF, got);
    txn("t1 lw", 1'b1, 1'b0, 3'd0, 32'h10, 32'h0, got);
    chk("t1 lw const", got, 32'hDEADBEEF);

    // Byte store and signed/unsigned byte loads.
    txn("t2 sb", 1'b0, 1'b1, 3'd3, 32'h11, 32'h00000080, got);
    txn("t2 lb", 1'b1, 1'b0, 3'd3, 32'h11, 32'h0, got);
    chk("t2 lb const", got, 32'hFFFFFF80);
    txn("t2 lbu", 1'b1, 1'b0, 3'd4, 32'h11, 32'h0, got);
    chk("t2 lbu const", got, 32'h00000080);
    txn("t2 lw", 1'b1, 1'b0, 3'd0, 32'h10, 32'h0, got);
    chk("t2 lw const", got, 32'hDEAD80EF);

    // Half store and signed/unsigned half loads.
    txn("t3 sh", 1'b0, 1'b1, 3'd1, 32'h12, 32'h00008001, got);
    txn("t3 lh", 1'b1, 1'b0, 3'd1, 32'h12, 32'h0, got);
    chk("t3 lh const", got, 32'hFFFF8001);
    txn("t3 lhu", 1'b1, 1'b0, 3'd2, 32'h12, 32'h0, got);
    chk("t3 lhu const", got, 32'h00008001);
    txn("t3 lw", 1'b1, 1'b0, 3'd0, 32'h10, 32'h0, got);
    chk("t3 lw const", got, 32'h800180EF);

    // Error requests leave memory untouched.
    txn("t4 lw mis", 1'b1, 1'b0, 3'd0, 32'h13, 32'h0, got);
    txn("t4 sh mis", 1'b0, 1'b1, 3'd1, 32'h11, 32'hFFFFFFFF, got);
    txn("t4 type5", 1'b1, 1'b0, 3'd5, 32'h10, 32'h0, got);
    txn("t4 rd+wr", 1'b1, 1'b1, 3'd0, 32'h10, 32'h12345678, got);
    txn("t4 sbu", 1'b0, 1'b1, 3'd4, 32'h10, 32'h000000AA, got);
    txn("t4 lw", 1'b1, 1'b0, 3'd0, 32'h10, 32'h0, got);
    chk("t4 lw const", got, 32'h800180EF);

    // Back-to-back loads with the request held high.
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; dm_type = 3'd0; addr = 32'h10;
    @(negedge clk);
    chk("b2b c1 ready", {31'b0, req_ready}, 32'd0);
    chk("b2b c1 stall", {31'b0, stall}, 32'd1);
    chk("b2b c1 rsp", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("b2b c2 ready", {31'b0, req_ready}, 32'd0);
    chk("b2b c2 rsp", {31'b0, rsp_valid}, 32'd1);
    chk("b2b c2 rdata", rdata, model_load(3'd0, 32'h10));
    addr = 32'h400;
    @(negedge clk);
    chk("b2b c3 ready", {31'b0, req_ready}, 32'd1);
    chk("b2b c3 stall", {31'b0, stall}, 32'd0);
    chk("b2b c3 rsp", {31'b0, rsp_valid}, 32'd0);
    @(negedge clk);
    mem_read = 1'b0;
    chk("b2b c4 ready", {31'b0, req_ready}, 32'd0);
    @(negedge clk);
    chk("b2b c5 rsp", {31'b0, rsp_valid}, 32'd1);
    chk("b2b wrap rdata", rdata, model_load(3'd0, 32'h0));
    last_rdata = model_load(3'd0, 32'h0);

    // Reset in the middle of a load.
    @(negedge clk);
    mem_read = 1'b1; dm_type = 3'd0; addr = 32'h20;
    @(negedge clk);
    mem_read = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rst mid rsp", {31'b0, rsp_valid}, 32'd0);
    chk("rst mid rdata", rdata, 32'd0);
    chk("rst mid err", {31'b0, err}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst hold rsp", {31'b0, rsp_valid}, 32'd0);
    end
    rstn = 1'b1;
    last_rdata = 32'h0;
    @(negedge clk);
    chk("rst release ready", {31'b0, req_ready}, 32'd1);
    chk("rst release rsp", {31'b0, rsp_valid}, 32'd0);
    txn("wrap lw 0x400", 1'b1, 1'b0, 3'd0, 32'h400, 32'h0, got);

    // Randomized traffic over words 0..15 with random upper address bits.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [2:0]  t;
      int          op;
      bit          rd;
      bit          wr;
      a = $urandom();
      a[9:6] = 4'b0000;
      t = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        if (t == 3'd0) a[1:0] = 2'b00;
        else if (t <= 3'd2) a[0] = 1'b0;
      end
      op = $urandom_range(0, 9);
      rd = (op == 0) || (op >= 5);
      wr = (op <= 4);
      txn("rand", rd, wr, t, a, $urandom(), got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
